report_time: RTL and testbench
==============================

REPORT_TIME -- requirements
Module: report_time

Interface
REQ-001 Parameter AUTO_PERIOD, default 0: clk cycles between automatic reports; 0 disables automatic reporting.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 report_req  input  1  one-cycle request to transmit one time/date frame.
REQ-005 time_i  input  24  current time from RTC, {HH,MM,SS}, BCD.
REQ-006 date_i  input  32  current date from RTC, {YY,MM,DD,WW}, BCD.
REQ-007 uart_tx_ready  input  1  UART transmitter accepts a byte this cycle.
REQ-008 uart_tx_data  output  8  byte offered to UART transmitter.
REQ-009 uart_tx_valid  output  1  uart_tx_data is valid.
REQ-010 busy  output  1  frame in progress (states SEND or DONE).
REQ-011 done  output  1  one-cycle pulse after the last byte of a frame is accepted.

Function
REQ-012 Frame SHALL be 13 bytes, in order: F0 F1 F2 YY MM DD WW HH MM SS F2 F1 F0. This is the same layout the UART time-set receiver expects, so a looped-back frame sets the RTC.
REQ-013 Byte n (0..12) SHALL be: 0:8'hF0, 1:8'hF1, 2:8'hF2, 3..6: snapshot date[31:24],[23:16],[15:8],[7:0], 7..9: snapshot time[23:16],[15:8],[7:0], 10:8'hF2, 11:8'hF1, 12:8'hF0.
REQ-014 FSM states SHALL be IDLE, SEND and DONE.
REQ-015 IDLE: on a start condition (report_req, pending flag, or auto tick), the block SHALL capture time_i and date_i into snapshot registers, set byte index to 0, and enter SEND on the next edge.
REQ-016 The snapshot SHALL NOT change until the frame completes; input changes mid-frame SHALL NOT alter transmitted bytes.
REQ-017 SEND: uart_tx_valid SHALL be 1 and uart_tx_data SHALL equal byte[index].
REQ-018 Handshake: a byte SHALL transfer only on a cycle where uart_tx_valid and uart_tx_ready are both 1. uart_tx_data SHALL be held stable while valid=1 and ready=0.
REQ-019 On transfer with index<12, index SHALL increment and the next byte SHALL be presented on the following cycle. Back-to-back transfers at one byte per cycle SHALL be supported.
REQ-020 On transfer with index==12, the FSM SHALL enter DONE and uart_tx_valid SHALL drop to 0 on the next cycle.
REQ-021 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Latency: report_req in cycle t SHALL give uart_tx_valid=1 with byte F0 in cycle t+1.
REQ-023 Requests in SEND or DONE SHALL set a one-deep pending flag. Further requests while the flag is set SHALL be dropped.
REQ-024 A pending request SHALL start a new frame on the first IDLE cycle after DONE, and the pending flag SHALL clear at that start.
REQ-025 Auto tick (AUTO_PERIOD>0): a free-running counter SHALL count 0..AUTO_PERIOD-1 and wrap. A tick SHALL occur on the wrap cycle and is handled exactly like report_req.
REQ-026 When report_req and an auto tick coincide, they SHALL produce one frame only.
REQ-027 uart_tx_ready while uart_tx_valid=0 SHALL be ignored.
REQ-028 busy SHALL be 1 in SEND and DONE, and 0 in IDLE.

Reset
REQ-029 rst=1 SHALL asynchronously force the following: state IDLE, index 0, uart_tx_valid 0, uart_tx_data 8'h00, busy 0, done 0, pending 0, auto counter 0, snapshots 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no further bytes and no done pulse. After release, the block SHALL wait for a new start condition.

Verification
REQ-031 Basic frame: time_i=24'h123456, date_i=32'h24061503, one report_req, ready held 1 -> 13 consecutive bytes F0 F1 F2 24 06 15 03 12 34 56 F2 F1 F0, then done pulse 1 cycle after last byte.
REQ-032 Backpressure: ready toggled randomly, including 5-cycle 0 stalls -> data stable during stalls, identical 13-byte sequence, no byte duplicated or skipped.
REQ-033 Snapshot: change time_i to 24'h235959 after byte 2 -> frame still carries 12 34 56.
REQ-034 Pending: three report_req during a frame -> exactly one extra frame, starting right after done, two frames total.
REQ-035 Auto: AUTO_PERIOD=100, no report_req, ready=1 -> frame starts every 100 cycles. A report_req on the tick cycle yields one frame.
REQ-036 Reset mid-frame: assert rst during byte 5 -> valid 0 immediately, no done. A later req sends a full frame from F0.

Source files
------------

// File: rtl/report_time.sv
// report_time: streams a 13-byte time/date frame (F0 F1 F2 YY MM DD WW HH MM SS F2 F1 F0)
// to a UART transmitter over a valid/ready byte handshake. Frames start on report_req,
// on an optional periodic auto tick, or on a request that was held pending during a frame.
module report_time #(
  parameter int AUTO_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        report_req,
  input  logic [23:0] time_i,
  input  logic [31:0] date_i,
  input  logic        uart_tx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd12;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        pending, pending_nxt;
  logic        start;
  logic        tick;
  logic        start_req;
  logic        xfer;
  logic [23:0] time_snap;
  logic [31:0] date_snap;

  // Byte n of the frame, built from the frozen snapshot so mid-frame input changes never leak out.
  function automatic logic [7:0] frame_byte(input logic [3:0] n,
                                            input logic [23:0] t,
                                            input logic [31:0] d);
    logic [7:0] b;
    case (n)
      4'd0:    b = 8'hF0;
      4'd1:    b = 8'hF1;
      4'd2:    b = 8'hF2;
      4'd3:    b = d[31:24];
      4'd4:    b = d[23:16];
      4'd5:    b = d[15:8];
      4'd6:    b = d[7:0];
      4'd7:    b = t[23:16];
      4'd8:    b = t[15:8];
      4'd9:    b = t[7:0];
      4'd10:   b = 8'hF2;
      4'd11:   b = 8'hF1;
      4'd12:   b = 8'hF0;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTO_PERIOD - 1);
      logic [CNT_W-1:0] auto_cnt;

      // Free-running 0..AUTO_PERIOD-1 counter; the wrap cycle is the auto tick.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          auto_cnt <= '0;
        end else if (auto_cnt == CNT_MAX) begin
          auto_cnt <= '0;
        end else begin
          auto_cnt <= auto_cnt + CNT_W'(1);
        end
      end

      assign tick = (auto_cnt == CNT_MAX);
    end else begin : g_no_auto
      assign tick = 1'b0;
    end
  endgenerate

  // A request and a coincident tick are one start condition, so they yield one frame.
  assign start_req = report_req | tick;
  assign xfer      = (state == SEND) & uart_tx_ready;

  // Next-state, byte index and one-deep pending flag.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pending_nxt = pending;
    start       = 1'b0;
    case (state)
      IDLE: begin
        if (start_req || pending) begin
          start       = 1'b1;
          state_nxt   = SEND;
          idx_nxt     = 4'd0;
          pending_nxt = 1'b0;
        end
      end
      SEND: begin
        if (start_req) begin
          pending_nxt = 1'b1;
        end
        if (xfer) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      DONE: begin
        if (start_req) begin
          pending_nxt = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control registers: state, index and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 4'd0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
    end
  end

  // Snapshot of time/date, captured only when a frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_snap <= 24'h0;
      date_snap <= 32'h0;
    end else if (start) begin
      time_snap <= time_i;
      date_snap <= date_i;
    end
  end

  // Outputs decode directly from state, so data holds steady for as long as ready stays low.
  always_comb begin
    uart_tx_valid = (state == SEND);
    uart_tx_data  = (state == SEND) ? frame_byte(idx, time_snap, date_snap) : 8'h00;
    busy          = (state != IDLE);
    done          = (state == DONE);
  end

endmodule

// File: tb/tb_report_time.sv
// Testbench for report_time: scoreboard of expected frame bytes plus a periodic-report instance.
module tb_report_time;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (no auto reporting)
  logic        rst, report_req, uart_tx_ready;
  logic [23:0] time_i;
  logic [31:0] date_i;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, busy, done;

  // Auto-reporting instance
  logic        rst_a, req_a, ready_a;
  logic [23:0] time_a;
  logic [31:0] date_a;
  logic [7:0]  data_a;
  logic        valid_a, busy_a, done_a;

  report_time #(.AUTO_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .report_req(report_req), .time_i(time_i), .date_i(date_i),
    .uart_tx_ready(uart_tx_ready), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .busy(busy), .done(done)
  );

  report_time #(.AUTO_PERIOD(100)) dut_auto (
    .clk(clk), .rst(rst_a), .report_req(req_a), .time_i(time_a), .date_i(date_a),
    .uart_tx_ready(ready_a), .uart_tx_data(data_a), .uart_tx_valid(valid_a),
    .busy(busy_a), .done(done_a)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic bp_mode  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: the byte list written out directly from the frame definition.
  function automatic logic [7:0] frame_at(input int n, input logic [23:0] t, input logic [31:0] d);
    logic [7:0] f [13];
    f = '{8'hF0, 8'hF1, 8'hF2, d[31:24], d[23:16], d[15:8], d[7:0],
          t[23:16], t[15:8], t[7:0], 8'hF2, 8'hF1, 8'hF0};
    return f[n];
  endfunction

  task automatic push_frame(input logic [23:0] t, input logic [31:0] d);
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      e.data = frame_at(i, t, d);
      e.last = (i == 12);
      sb.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    cyc(1);
    report_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      cyc(1);
      k++;
    end
    check("drain_within_budget", (k < budget), 1);
  endtask

  // Ready driver: constant 1, or random with occasional 5-cycle stalls.
  initial begin
    int stall;
    stall = 0;
    uart_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!bp_mode) begin
        uart_tx_ready = 1'b1;
        stall = 0;
      end else if (stall > 0) begin
        uart_tx_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 7) == 0) begin
        uart_tx_ready = 1'b0;
        stall = 4;
      end else begin
        uart_tx_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor for the main instance: pops the scoreboard on every accepted byte.
  initial begin
    logic       done_exp, prev_stall;
    logic [7:0] prev_data;
    exp_t       e;
    done_exp   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_exp   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check("done_timing", done, done_exp);
        if (uart_tx_valid || done) check("busy_in_frame", busy, 1);
        if (prev_stall) begin
          check("stall_valid_held", uart_tx_valid, 1);
          check("stall_data_held", uart_tx_data, prev_data);
        end
        done_exp = 1'b0;
        if (uart_tx_valid && uart_tx_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h, expected no transfer (t=%0t)", uart_tx_data, $time);
          end else begin
            e = sb.pop_front();
            check("frame_byte", uart_tx_data, e.data);
            done_exp = e.last;
          end
        end
        prev_stall = uart_tx_valid && !uart_tx_ready;
        prev_data  = uart_tx_data;
      end
    end
  end

  // Auto instance bookkeeping
  int cyc_a = 0;
  int starts[$];
  int bytes_a = 0;

  always @(posedge clk) cyc_a <= cyc_a + 1;

  initial begin
    logic prev_valid;
    int   pos;
    prev_valid = 1'b0;
    pos = 0;
    forever begin
      @(negedge clk);
      if (!rst_a) begin
        if (valid_a && !prev_valid) starts.push_back(cyc_a);
        if (valid_a && ready_a) begin
          check("auto_byte", data_a, frame_at(pos, time_a, date_a));
          pos = (pos + 1) % 13;
          bytes_a++;
        end
        prev_valid = valid_a;
      end
    end
  end

  initial begin
    rst = 1'b1;
    report_req = 1'b0;
    time_i = 24'h000000;
    date_i = 32'h00000000;
    rst_a = 1'b1;
    req_a = 1'b0;
    ready_a = 1'b1;
    time_a = 24'h091500;
    date_a = 32'h25123104;

    fork
      // Periodic reporting and a request coinciding with a tick
      begin
        int rel, s, k;
        cyc(3);
        rst_a = 1'b0;
        rel = cyc_a;
        k = 0;
        while (starts.size() == 0 && k < 300) begin
          cyc(1);
          k++;
        end
        check("auto_first_start_seen", (starts.size() != 0), 1);
        if (starts.size() != 0) begin
          s = starts[0];
          check("auto_first_start_cycle", s, rel + 100);
          while (cyc_a < s + 99) cyc(1);
          req_a = 1'b1;
          cyc(1);
          req_a = 1'b0;
          while (cyc_a < s + 350) cyc(1);
          check("auto_frame_count", starts.size(), 4);
          for (int i = 1; i < starts.size(); i++)
            check("auto_period", starts[i] - starts[i-1], 100);
          check("auto_byte_count", bytes_a, 13 * starts.size());
        end
      end

      // Main instance tests
      begin
        logic [23:0] t;
        logic [31:0] d;
        int k;

        @(negedge clk);
        check("rst_valid", uart_tx_valid, 0);
        check("rst_data", uart_tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        cyc(1);
        rst = 1'b0;
        cyc(2);

        // Basic frame with one-cycle latency
        time_i = 24'h123456;
        date_i = 32'h24061503;
        push_frame(time_i, date_i);
        pulse_req();
        check("latency_valid", uart_tx_valid, 1);
        check("latency_first_byte", uart_tx_data, 8'hF0);
        wait_idle(100);
        check("idle_after_frame", busy, 0);

        // Snapshot held while inputs change mid-frame
        push_frame(24'h123456, 32'h24061503);
        pulse_req();
        cyc(3);
        time_i = 24'h235959;
        date_i = 32'h99123106;
        wait_idle(100);
        time_i = 24'h123456;
        date_i = 32'h24061503;
        cyc(2);

        // Three requests during a frame give exactly one extra frame
        push_frame(time_i, date_i);
        push_frame(time_i, date_i);
        pulse_req();
        cyc(2);
        pulse_req();
        cyc(3);
        pulse_req();
        cyc(3);
        pulse_req();
        k = 0;
        while (!done && k < 100) begin
          @(negedge clk);
          k++;
        end
        check("pending_done_seen", done, 1);
        @(negedge clk);
        check("pending_gap_busy", busy, 0);
        check("pending_gap_valid", uart_tx_valid, 0);
        @(negedge clk);
        check("pending_restart_valid", uart_tx_valid, 1);
        check("pending_restart_byte", uart_tx_data, 8'hF0);
        wait_idle(100);
        cyc(5);

        // Random data under random backpressure
        bp_mode = 1'b1;
        for (int f = 0; f < 4; f++) begin
          t = 24'($urandom);
          d = $urandom;
          time_i = t;
          date_i = d;
          push_frame(t, d);
          pulse_req();
          wait_idle(800);
          cyc($urandom_range(1, 4));
        end
        bp_mode = 1'b0;
        cyc(3);

        // Reset in the middle of byte 5
        time_i = 24'h101010;
        date_i = 32'h20202020;
        push_frame(time_i, date_i);
        pulse_req();
        cyc(5);
        rst = 1'b1;
        #1;
        check("midrst_valid", uart_tx_valid, 0);
        check("midrst_data", uart_tx_data, 8'h00);
        check("midrst_busy", busy, 0);
        sb.delete();
        @(negedge clk);
        check("midrst_no_done", done, 0);
        cyc(1);
        rst = 1'b0;
        cyc(20);
        check("post_rst_idle", busy, 0);
        t = 24'($urandom);
        d = $urandom;
        time_i = t;
        date_i = d;
        push_frame(t, d);
        pulse_req();
        check("post_rst_first_byte", uart_tx_data, 8'hF0);
        wait_idle(100);
        cyc(3);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
